// File: rtl/niosqsys_onchip_mem_arb_pkg.sv
// Shared types and constants for the on-chip memory arbiter.
//   arb_state_t : arbitration state (free arbitration, or locked to one master)
//   M0 / M1     : master identifiers, used as grant/request bit indices
package niosqsys_onchip_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/niosqsys_rr_grant2.sv
// Combinational two-way round-robin grant.
//   req        in  [1:0] request per master
//   last_grant in  1     id of the master granted most recently
//   mask       in  [1:0] masters allowed to be granted this cycle
//   grant      out [1:0] one-hot (or zero) grant
module niosqsys_rr_grant2
    import niosqsys_onchip_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req & mask;
        grant    = eligible;
        // On contention the master that was not served last wins.
        if (eligible == 2'b11) begin
            grant = (last_grant == M1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/niosqsys_onchip_mem_arbiter.sv
// Two-master arbiter in front of the single-port on-chip memory (s1 port).
// Grants at most one Avalon-MM transfer per cycle, round-robin on contention,
// honours master lock with a bounded hold time, and routes the one-cycle-late
// read data back to the master that issued the read.
//   clk, reset              clock and asynchronous active-high reset
//   m0_* / m1_*             Avalon-MM master-side command and response ports
//   mem_*                   memory command outputs, mem_readdata input
module niosqsys_onchip_mem_arbiter
    import niosqsys_onchip_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BE_W     = 4,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int unsigned      CNT_W     = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] LOCK_SAT  = CNT_W'(LOCK_MAX);

    arb_state_t       state;
    logic             last_grant;
    logic             rd_pend;
    logic             rd_owner;
    logic [CNT_W-1:0] lock_cnt;

    logic [1:0] req;
    logic [1:0] wr;
    logic [1:0] lock;
    logic [1:0] mask;
    logic [1:0] grant;
    logic       gnt_any;
    logic       gnt_id;
    logic       gnt_write;
    logic       gnt_lock;
    logic       owner;
    logic       lock_timeout;
    logic       lock_release;

    assign req  = {m1_read | m1_write, m0_read | m0_write};
    assign wr   = {m1_write, m0_write};
    assign lock = {m1_lock, m0_lock};

    // While in reset nobody is granted; in a lock state only the owner is.
    always_comb begin
        mask = 2'b00;
        if (!reset) begin
            case (state)
                ARB:     mask = 2'b11;
                LOCK0:   mask = 2'b01;
                LOCK1:   mask = 2'b10;
                default: mask = 2'b00;
            endcase
        end
    end

    niosqsys_rr_grant2 u_grant (
        .req        (req),
        .last_grant (last_grant),
        .mask       (mask),
        .grant      (grant)
    );

    assign gnt_any   = |grant;
    assign gnt_id    = grant[M1];
    // A simultaneous read+write counts as a write.
    assign gnt_write = |(grant & wr);
    assign gnt_lock  = |(grant & lock);

    assign owner        = (state == LOCK1) ? M1 : M0;
    assign lock_timeout = (lock_cnt == LOCK_LAST);
    // The owner is always granted when it requests, so dropping lock releases
    // both after a final unlocked transfer and when the owner is idle.
    assign lock_release = ~lock[owner] | lock_timeout;

    assign m0_waitrequest = req[M0] & ~grant[M0];
    assign m1_waitrequest = req[M1] & ~grant[M1];

    assign mem_address    = grant[M1] ? m1_address    : m0_address;
    assign mem_byteenable = grant[M1] ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant[M1] ? m1_writedata  : m0_writedata;
    assign mem_chipselect = gnt_any;
    assign mem_write      = gnt_write;
    assign mem_clken      = ~reset;

    assign m0_readdatavalid = rd_pend & (rd_owner == M0);
    assign m1_readdatavalid = rd_pend & (rd_owner == M1);
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            last_grant <= M1;
            rd_pend    <= 1'b0;
            rd_owner   <= M0;
            lock_cnt   <= '0;
        end else begin
            rd_pend  <= gnt_any & ~gnt_write;
            rd_owner <= gnt_any & ~gnt_write & gnt_id;
            if (gnt_any) begin
                last_grant <= gnt_id;
            end
            case (state)
                ARB: begin
                    if (gnt_any && gnt_lock) begin
                        state    <= gnt_id ? LOCK1 : LOCK0;
                        lock_cnt <= '0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (lock_cnt != LOCK_SAT) begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                    if (lock_release) begin
                        state <= ARB;
                        // Forced release hands the next tie to the other master.
                        if (lock_timeout) begin
                            last_grant <= owner;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: doc/niosqsys_onchip_mem_arbiter.md
# niosqsys_onchip_mem_arbiter

Two-master arbiter sharing the single-port 1024×32 on-chip memory between two Avalon-MM masters, e.g. the Nios II data master and a DMA engine. It grants at most one transfer per cycle with round-robin fairness and supports Avalon `lock` for atomic sequences, bounded by a timeout. It tracks the memory's one-cycle read latency and routes `readdata`/`readdatavalid` back to the issuing master. It sits between the two masters and the memory's s1 slave port.

## Interface
- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byteenable width (`DATA_W`/8)
- `LOCK_MAX`, 64, maximum consecutive cycles a lock may hold the memory; must be ≥ 1

Ports:
- `clk`  in  1  single clock; all logic is in this domain
- `reset`  in  1  asynchronous, active-high reset
- `m0_address`/`m1_address`  in  `ADDR_W`  word address
- `m0_byteenable`/`m1_byteenable`  in  `BE_W`  byte lanes
- `m0_read`/`m1_read`  in  1  read request
- `m0_write`/`m1_write`  in  1  write request
- `m0_writedata`/`m1_writedata`  in  `DATA_W`  write data
- `m0_lock`/`m1_lock`  in  1  keep the grant after this transfer
- `m0_waitrequest`/`m1_waitrequest`  out  1  command not accepted this cycle
- `m0_readdata`/`m1_readdata`  out  `DATA_W`  read data
- `m0_readdatavalid`/`m1_readdatavalid`  out  1  read data valid
- `mem_address`  out  `ADDR_W`
- `mem_byteenable`  out  `BE_W`
- `mem_chipselect`  out  1
- `mem_write`  out  1
- `mem_writedata`  out  `DATA_W`
- `mem_clken`  out  1
- `mem_readdata`  in  `DATA_W`  memory output, valid one cycle after the address is presented

## Operation
- **Request.** `req_i = mi_read | mi_write`. A master holds its command stable while `mi_waitrequest` = 1.
- **Simultaneous read and write.** If a master asserts read and write together, it is treated as a write; no readdatavalid follows.
- **Grant.** The grant is combinational and at most one master is granted per cycle.
  - A single requester is granted immediately.
  - When both request, the master not in `last_grant` wins.
  - `last_grant` updates on every granted cycle.
- **Waitrequest.** `mi_waitrequest = req_i & ~grant_i`. It is 0 when the master is not requesting.
- **Memory command.** The memory port is driven from the granted master's command.
  - `mem_chipselect = |grant`
  - `mem_write` = granted master's write
  - When nothing is granted, `mem_address`, `mem_byteenable` and `mem_writedata` take master 0's values and `mem_chipselect` = 0.
  - `mem_clken = ~reset`.
- **Read tracking.** `rd_pend` and `rd_owner` registers are set on a granted read and cleared otherwise.
  - `mi_readdatavalid = rd_pend & (rd_owner == i)`.
  - `mi_readdata = mem_readdata` when that master's readdatavalid is 1, else 0.
- **State machine** (3 states: `ARB`, `LOCK0`, `LOCK1`):
  - `ARB` → `LOCKi`: on a granted transfer from master i with `mi_lock` = 1.
  - In `LOCKi`, only master i can be granted; the other master sees waitrequest = 1.
  - `LOCKi` → `ARB`, on the first of:
    - a granted transfer from master i with `mi_lock` = 0 (that transfer completes);
    - master i idle with `mi_lock` = 0;
    - `lock_cnt` reaching `LOCK_MAX - 1`.
  - On a forced (timeout) release, `last_grant` = i, so the other master wins the next contention.
- **Lock counter.** `lock_cnt` has width `$clog2(LOCK_MAX+1)`. It clears on entry to `LOCKi`, increments each cycle in `LOCKi`, and saturates.

## Timing
- **Reset values.**
  - State `ARB`; `last_grant` = 1, so master 0 wins the first tie.
  - `rd_pend` = 0; `lock_cnt` = 0.
  - All readdatavalid = 0; all readdata = 0.
  - `mem_chipselect` = 0; `mem_write` = 0; `mem_clken` = 0.
  - Waitrequest = 1 for any requesting master while `reset` is high.
- **Latency.**
  - Grant and command to memory: 0 cycles.
  - Read data: readdatavalid is exactly 1 cycle after the accepted read cycle.
  - Write: completes in the accepted cycle.
- **Throughput.** One transfer per cycle; back-to-back reads from either master are fully pipelined.
- **Reset mid-read.** An asserted `reset` drops a pending read; no readdatavalid is produced after reset.
- **Lock entry.** A lock requested while in `ARB` takes effect from the cycle after the locking transfer.

## Structure
- Package `niosqsys_onchip_mem_arb_pkg` holds:
  - the state enum `arb_state_t` {`ARB`, `LOCK0`, `LOCK1`};
  - master-id constants `M0` = 0 and `M1` = 1.
- One sub-module, `niosqsys_rr_grant2`: a combinational 2-way round-robin grant from `req[1:0]`, `last_grant` and `mask[1:0]` (the lock restriction).
- Registers (`state`, `last_grant`, `rd_pend`, `rd_owner`, `lock_cnt`) live in the top level.

## Test plan
- **Alternating reads.** m0 and m1 read continuously from 0x010 and 0x020 → grants alternate m0, m1, m0, …; each master's readdatavalid arrives 1 cycle after its grant, carrying the correct data.
- **Single master streaming.** m0 alone writes 0xDEADBEEF to 0x3FF with be=0xF, then reads 0x3FF → zero waitrequest; readdatavalid on the next cycle with 0xDEADBEEF.
- **Contention with a partial write.**
  - Stimulus: m1 writes be=0x3 of 0x12345678 to 0x005 while m0 is requesting.
  - Required: m0 waits exactly 1 cycle.
  - A subsequent read of 0x005 returns only the two low bytes updated (0x5678), upper bytes unchanged.
- **Lock hold and release.**
  - Stimulus: m0 performs three locked reads while m1 requests continuously.
  - Required: m1 waitrequest stays 1 throughout; m1 is granted in the cycle after m0's unlocked final transfer.
- **Lock timeout.** With `LOCK_MAX`=4, m0 holds lock while idle → forced release after 4 cycles, then m1 is granted.
- **Reset mid-read.** Assert reset in the cycle after a granted read → no readdatavalid; all outputs at their reset values.
